// File: rtl/mem_port_arbiter_pkg.sv
// ============================================================================
// mem_port_arbiter_pkg : state encoding, requester IDs and defaults
// Revision: 1.0
// ============================================================================
`default_nettype none

package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_BUSY_A = 2'b01,
    ST_BUSY_B = 2'b10
  } state_e;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  localparam int DEFAULT_TIMEOUT = 16;

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
// ============================================================================
// mem_port_arbiter_if : requester, memory and status signals of the arbiter
// Revision: 1.0
// ============================================================================
`default_nettype none

interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req_a;
  logic              we_a;
  logic [ADDR_W-1:0] addr_a;
  logic [DATA_W-1:0] wdata_a;
  logic              req_b;
  logic              we_b;
  logic [ADDR_W-1:0] addr_b;
  logic [DATA_W-1:0] wdata_b;
  logic              done_a;
  logic              done_b;
  logic              err_a;
  logic              err_b;
  logic [DATA_W-1:0] rdata;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  logic              sel;
  logic              busy;

  // Arbiter side
  modport slave (
    input  req_a, we_a, addr_a, wdata_a,
    input  req_b, we_b, addr_b, wdata_b,
    input  mem_rdata, mem_ready,
    output done_a, done_b, err_a, err_b, rdata,
    output mem_req, mem_we, mem_addr, mem_wdata, sel, busy
  );

  // Requesters plus memory side
  modport master (
    output req_a, we_a, addr_a, wdata_a,
    output req_b, we_b, addr_b, wdata_b,
    output mem_rdata, mem_ready,
    input  done_a, done_b, err_a, err_b, rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, sel, busy
  );

endinterface

`default_nettype wire

// File: rtl/mem_port_arbiter_mux_2to1.sv
// ============================================================================
// mux_2to1 : width-parameterised 2-to-1 select (0 = a, 1 = b)
// Revision: 1.0
// ============================================================================
`default_nettype none

module mux_2to1 #(
  parameter int WIDTH = 1
) (
  input  logic             sel_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] y_o
);

  assign y_o = sel_i ? b_i : a_i;

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// mem_port_arbiter : round-robin sharing of one memory port between fetch (A)
//                    and data (B) with a per-grant watchdog
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                clk_i,
  input  logic                rst_i,
  mem_port_arbiter_if.slave   bus_if
);

  localparam int             CNT_W   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic             sel_q,   sel_d;
  logic             last_q,  last_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  logic w_busy_a;
  logic w_busy_b;
  logic w_timeout;
  logic w_other_req;

  assign w_busy_a  = (state_q == ST_BUSY_A);
  assign w_busy_b  = (state_q == ST_BUSY_B);
  assign w_timeout = (cnt_q == CNT_MAX) && !bus_if.mem_ready;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      sel_q   <= REQ_A;
      last_q  <= REQ_B;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    w_other_req = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus_if.req_a && (!bus_if.req_b || last_q == REQ_B)) begin
          state_d = ST_BUSY_A;
          sel_d   = REQ_A;
          cnt_d   = '0;
        end else if (bus_if.req_b) begin
          state_d = ST_BUSY_B;
          sel_d   = REQ_B;
          cnt_d   = '0;
        end
      end
      ST_BUSY_A, ST_BUSY_B: begin
        if (bus_if.mem_ready || w_timeout) begin
          // Owner is masked: only the other side can be granted this cycle
          last_d      = w_busy_b ? REQ_B : REQ_A;
          w_other_req = w_busy_b ? bus_if.req_a : bus_if.req_b;
          if (w_other_req) begin
            state_d = w_busy_b ? ST_BUSY_A : ST_BUSY_B;
            sel_d   = w_busy_b ? REQ_A : REQ_B;
            cnt_d   = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus_if.done_a  = w_busy_a && bus_if.mem_ready;
  assign bus_if.done_b  = w_busy_b && bus_if.mem_ready;
  assign bus_if.err_a   = w_busy_a && w_timeout;
  assign bus_if.err_b   = w_busy_b && w_timeout;
  assign bus_if.rdata   = bus_if.mem_rdata;
  assign bus_if.mem_req = w_busy_a || w_busy_b;
  assign bus_if.busy    = (state_q != ST_IDLE);
  assign bus_if.sel     = sel_q;

  mux_2to1 #(.WIDTH(ADDR_W)) u_mux_addr (
    .sel_i (sel_q),
    .a_i   (bus_if.addr_a),
    .b_i   (bus_if.addr_b),
    .y_o   (bus_if.mem_addr)
  );

  mux_2to1 #(.WIDTH(DATA_W)) u_mux_wdata (
    .sel_i (sel_q),
    .a_i   (bus_if.wdata_a),
    .b_i   (bus_if.wdata_b),
    .y_o   (bus_if.mem_wdata)
  );

  mux_2to1 #(.WIDTH(1)) u_mux_we (
    .sel_i (sel_q),
    .a_i   (bus_if.we_a),
    .b_i   (bus_if.we_b),
    .y_o   (bus_if.mem_we)
  );

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// tb_mem_port_arbiter : directed self-checking bench for mem_port_arbiter
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

  logic clk;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus_if ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .bus_if (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    rst              = 1'b1;
    bus_if.req_a     = 1'b0;
    bus_if.we_a      = 1'b0;
    bus_if.addr_a    = '0;
    bus_if.wdata_a   = '0;
    bus_if.req_b     = 1'b0;
    bus_if.we_b      = 1'b0;
    bus_if.addr_b    = '0;
    bus_if.wdata_b   = '0;
    bus_if.mem_rdata = '0;
    bus_if.mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    settle();
    chk("rst_mem_req", bus_if.mem_req, 0);
    chk("rst_sel",     bus_if.sel,     0);
    chk("rst_busy",    bus_if.busy,    0);
    chk("rst_done_err", {bus_if.done_a, bus_if.done_b, bus_if.err_a, bus_if.err_b}, 0);

    // Single A read
    bus_if.req_a  = 1'b1;
    bus_if.addr_a = 32'h0000_0100;
    nxt(); settle();
    chk("rdA_c1_mem_req", bus_if.mem_req, 1);
    chk("rdA_c1_sel",     bus_if.sel, 0);
    chk("rdA_c1_addr",    bus_if.mem_addr, 32'h100);
    chk("rdA_c1_we",      bus_if.mem_we, 0);
    chk("rdA_c1_done",    bus_if.done_a, 0);
    nxt(); settle();
    chk("rdA_c2_mem_req", bus_if.mem_req, 1);
    nxt();
    bus_if.mem_ready = 1'b1;
    bus_if.mem_rdata = 32'hDEAD_BEEF;
    bus_if.req_a     = 1'b0;
    settle();
    chk("rdA_c3_mem_req", bus_if.mem_req, 1);
    chk("rdA_c3_done_a",  bus_if.done_a, 1);
    chk("rdA_c3_err_a",   bus_if.err_a, 0);
    chk("rdA_c3_rdata",   bus_if.rdata, 32'hDEAD_BEEF);
    nxt();
    bus_if.mem_ready = 1'b0;
    settle();
    chk("rdA_c4_busy",    bus_if.busy, 0);
    chk("rdA_c4_mem_req", bus_if.mem_req, 0);
    chk("rdA_c4_done_a",  bus_if.done_a, 0);

    // Asynchronous reset in the middle of a B write
    bus_if.req_b   = 1'b1;
    bus_if.we_b    = 1'b1;
    bus_if.addr_b  = 32'h0000_00B0;
    bus_if.wdata_b = 32'h0000_5555;
    nxt(); settle();
    chk("arst_pre_sel",   bus_if.sel, 1);
    chk("arst_pre_busy",  bus_if.busy, 1);
    chk("arst_pre_we",    bus_if.mem_we, 1);
    chk("arst_pre_addr",  bus_if.mem_addr, 32'hB0);
    chk("arst_pre_wdata", bus_if.mem_wdata, 32'h5555);
    bus_if.req_b = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("arst_mem_req", bus_if.mem_req, 0);
    chk("arst_sel",     bus_if.sel, 0);
    chk("arst_busy",    bus_if.busy, 0);
    rst = 1'b0;
    nxt(); settle();
    chk("arst_after_busy", bus_if.busy, 0);

    // Tie: both held, ready on every second BUSY cycle
    bus_if.addr_a = 32'h0000_00A0;
    bus_if.req_a  = 1'b1;
    bus_if.req_b  = 1'b1;
    nxt();
    for (int k = 0; k < 4; k++) begin
      settle();
      chk("rr_sel",  bus_if.sel, k % 2);
      chk("rr_busy", bus_if.busy, 1);
      chk("rr_addr", bus_if.mem_addr, (k % 2) ? 32'hB0 : 32'hA0);
      chk("rr_nodone", {bus_if.done_a, bus_if.done_b}, 0);
      nxt();
      bus_if.mem_ready = 1'b1;
      if (k == 3) begin
        bus_if.req_a = 1'b0;
        bus_if.req_b = 1'b0;
      end
      settle();
      chk("rr_done_a", bus_if.done_a, (k % 2) == 0);
      chk("rr_done_b", bus_if.done_b, (k % 2) == 1);
      nxt();
      bus_if.mem_ready = 1'b0;
    end
    settle();
    chk("rr_end_busy", bus_if.busy, 0);

    // B watchdog: no mem_ready ever
    bus_if.req_b = 1'b1;
    nxt();
    for (int i = 1; i <= 16; i++) begin
      if (i == 16) bus_if.req_b = 1'b0;
      settle();
      chk("to_err_b",  bus_if.err_b, (i == 16));
      chk("to_done_b", bus_if.done_b, 0);
      nxt();
    end
    settle();
    chk("to_after_busy",  bus_if.busy, 0);
    chk("to_after_err_b", bus_if.err_b, 0);

    // mem_ready arrives on the timeout cycle of an A read
    bus_if.req_a = 1'b1;
    nxt();
    for (int i = 1; i <= 16; i++) begin
      if (i == 16) begin
        bus_if.mem_ready = 1'b1;
        bus_if.mem_rdata = 32'h1234_5678;
        bus_if.req_a     = 1'b0;
        settle();
        chk("col_done_a", bus_if.done_a, 1);
        chk("col_err_a",  bus_if.err_a, 0);
        chk("col_rdata",  bus_if.rdata, 32'h1234_5678);
      end else begin
        settle();
        chk("col_pre_err_a", bus_if.err_a, 0);
      end
      nxt();
      bus_if.mem_ready = 1'b0;
    end
    settle();
    chk("col_after_busy", bus_if.busy, 0);

    // Masking: A held through done_a, no B request
    bus_if.req_a   = 1'b1;
    bus_if.we_a    = 1'b1;
    bus_if.wdata_a = 32'h0000_CAFE;
    nxt(); settle();
    chk("mask_c1_sel",   bus_if.sel, 0);
    chk("mask_c1_we",    bus_if.mem_we, 1);
    chk("mask_c1_wdata", bus_if.mem_wdata, 32'hCAFE);
    nxt();
    bus_if.mem_ready = 1'b1;
    settle();
    chk("mask_c2_done_a", bus_if.done_a, 1);
    nxt();
    bus_if.mem_ready = 1'b0;
    settle();
    chk("mask_c3_busy",    bus_if.busy, 0);
    chk("mask_c3_mem_req", bus_if.mem_req, 0);
    nxt(); settle();
    chk("mask_c4_busy", bus_if.busy, 1);
    chk("mask_c4_sel",  bus_if.sel, 0);
    bus_if.mem_ready = 1'b1;
    bus_if.req_a     = 1'b0;
    settle();
    chk("mask_c4_done_a", bus_if.done_a, 1);
    nxt();

    // mem_ready while IDLE produces nothing
    settle();
    chk("idle_rdy_busy", bus_if.busy, 0);
    chk("idle_rdy_flags", {bus_if.done_a, bus_if.done_b, bus_if.err_a, bus_if.err_b}, 0);
    bus_if.mem_ready = 1'b0;
    nxt(); settle();
    chk("idle_rdy_after_busy", bus_if.busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
